frame_capture_buffer: RTL and testbench

- Sits directly downstream of frame_detector, on the same rx_cpack ADC sample stream.
- Continuously records I/Q samples into a ring buffer. On a detection pulse, freezes PRE_LEN pre-trigger samples plus FRAME_LEN post-trigger samples.
- Streams the captured frame to the DMA/CPU over AXI-Stream, with the latched CFO estimate as sideband, so software demodulates only detected frames.

---
 rtl/frame_pkg.sv | 25 ++
 rtl/frame_capture_ram.sv | 35 +++
 rtl/frame_capture_buffer.sv | 232 +++++++++++++++++++++++
 tb/tb_frame_capture_buffer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the frame detection / capture path.
// Default lengths live here so the detector, the capture buffer and the
// software headers agree on the frame geometry.
package frame_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;
    localparam int CFO_WIDTH_DEFAULT  = 16;
    localparam int PRE_LEN_DEFAULT    = 32;
    localparam int FRAME_LEN_DEFAULT  = 256;
    localparam int DEPTH_DEFAULT      = 512;

    // One complex sample as stored in the ring and emitted on the stream:
    // Q in the upper half, I in the lower half.
    typedef struct packed {
        logic [DATA_WIDTH_DEFAULT-1:0] q;
        logic [DATA_WIDTH_DEFAULT-1:0] i;
    } sample_t;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        CAPTURE = 2'd1,
        READOUT = 2'd2
    } state_t;

endpackage

// File: rtl/frame_capture_ram.sv
// Simple dual-port sample RAM: one write port, one read port with a
// registered output (1-cycle latency). Written so it maps onto block RAM.
module frame_capture_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; output holds when no read is requested
    always_ff @(posedge clk) begin
        if (re) begin
            rd_data_reg <= mem[raddr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/frame_capture_buffer.sv
// Records the I/Q stream into a ring buffer, freezes PRE_LEN samples before
// a detection pulse plus FRAME_LEN samples from it onward, then streams the
// frame out over AXI-Stream with the CFO estimate latched on tuser.
module frame_capture_buffer
    import frame_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int CFO_WIDTH  = CFO_WIDTH_DEFAULT,
    parameter int PRE_LEN    = PRE_LEN_DEFAULT,
    parameter int FRAME_LEN  = FRAME_LEN_DEFAULT,
    parameter int DEPTH      = DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [DATA_WIDTH-1:0]   adc_data_i0,
    input  logic [DATA_WIDTH-1:0]   adc_data_q0,
    input  logic                    adc_enable_i0,
    input  logic                    adc_valid_i0,
    input  logic                    adc_enable_q0,
    input  logic                    adc_valid_q0,
    input  logic                    frame_detected_nirq,
    input  logic [CFO_WIDTH-1:0]    cfo_estimate,
    output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [CFO_WIDTH-1:0]    m_axis_tuser,
    output logic                    busy,
    output logic [15:0]             missed_trigger_count,
    output logic [31:0]             dropped_sample_count
);

    localparam int TOTAL = PRE_LEN + FRAME_LEN;
    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = $clog2(PRE_LEN + 1);
    localparam int RW    = $clog2(FRAME_LEN + 1);
    localparam int BW    = $clog2(TOTAL + 1);
    localparam int SW    = 2 * DATA_WIDTH;

    if (DEPTH < TOTAL) begin : g_depth_too_small
        $error("frame_capture_buffer: DEPTH must hold PRE_LEN+FRAME_LEN samples");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_not_pow2
        $error("frame_capture_buffer: DEPTH must be a power of two");
    end

    state_t               state_reg, state_next;
    logic [AW-1:0]        wr_ptr_reg, wr_ptr_next;
    logic [FW-1:0]        fill_reg, fill_next;
    logic [RW-1:0]        remaining_reg, remaining_next;
    logic [AW-1:0]        rd_ptr_reg, rd_ptr_next;
    logic [BW-1:0]        issued_reg, issued_next;
    logic [CFO_WIDTH-1:0] cfo_reg, cfo_next;
    logic [15:0]          missed_reg, missed_next;
    logic [31:0]          dropped_reg, dropped_next;
    logic                 busy_reg;

    // Skid/prefetch control: two slots, head/tail pointers and occupancy
    logic                 head_reg, tail_reg;
    logic [1:0]           count_reg, count_after;
    logic                 rd_inflight_reg, rd_last_reg;

    logic                 sample_valid, trigger, trigger_accepted;
    logic                 ram_we, rd_issue, rd_issue_last;
    logic                 push, pop, last_pop;
    logic [SW-1:0]        ram_rd_data, head_data;
    logic                 head_last;

    assign sample_valid     = adc_enable_i0 & adc_valid_i0 & adc_enable_q0 & adc_valid_q0;
    assign trigger          = ~frame_detected_nirq;
    assign trigger_accepted = trigger && (state_reg == ARMED) && (fill_reg == FW'(PRE_LEN));

    assign ram_we = sample_valid && ((state_reg == ARMED) || (state_reg == CAPTURE));

    // A read is only issued if the slot it will land in is guaranteed free
    assign push          = rd_inflight_reg;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign count_after   = count_reg + {1'b0, push} - {1'b0, pop};
    assign rd_issue      = (state_reg == READOUT) && (issued_reg != BW'(TOTAL)) && (count_after < 2'd2);
    assign rd_issue_last = (issued_reg == BW'(TOTAL - 1));
    assign last_pop      = pop && head_last;

    frame_capture_ram #(
        .DEPTH (DEPTH),
        .WIDTH (SW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (wr_ptr_reg),
        .wdata   ({adc_data_q0, adc_data_i0}),
        .re      (rd_issue),
        .raddr   (rd_ptr_reg),
        .rd_data (ram_rd_data)
    );

    // Next-state, pointer and counter logic
    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        fill_next      = fill_reg;
        remaining_next = remaining_reg;
        rd_ptr_next    = rd_ptr_reg;
        issued_next    = issued_reg;
        cfo_next       = cfo_reg;
        missed_next    = missed_reg;
        dropped_next   = dropped_reg;

        if (trigger && !trigger_accepted && (missed_reg != '1)) begin
            missed_next = missed_reg + 16'd1;
        end
        if ((state_reg == READOUT) && sample_valid && (dropped_reg != '1)) begin
            dropped_next = dropped_reg + 32'd1;
        end

        case (state_reg)
            ARMED: begin
                if (sample_valid) begin
                    wr_ptr_next = wr_ptr_reg + AW'(1);
                    if (fill_reg != FW'(PRE_LEN)) begin
                        fill_next = fill_reg + FW'(1);
                    end
                end
                if (trigger_accepted) begin
                    // The trigger-cycle sample (if any) is the first post-trigger one
                    rd_ptr_next    = wr_ptr_reg - AW'(PRE_LEN);
                    cfo_next       = cfo_estimate;
                    issued_next    = '0;
                    remaining_next = RW'(FRAME_LEN) - RW'(sample_valid);
                    state_next     = (remaining_next == '0) ? READOUT : CAPTURE;
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    wr_ptr_next    = wr_ptr_reg + AW'(1);
                    remaining_next = remaining_reg - RW'(1);
                    if (remaining_reg == RW'(1)) begin
                        state_next = READOUT;
                    end
                end
            end
            READOUT: begin
                if (rd_issue) begin
                    rd_ptr_next = rd_ptr_reg + AW'(1);
                    issued_next = issued_reg + BW'(1);
                end
                if (last_pop) begin
                    // History is rebuilt from scratch before the next capture
                    state_next = ARMED;
                    fill_next  = '0;
                end
            end
            default: begin
                state_next = ARMED;
            end
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= ARMED;
            wr_ptr_reg    <= '0;
            fill_reg      <= '0;
            remaining_reg <= '0;
            rd_ptr_reg    <= '0;
            issued_reg    <= '0;
            cfo_reg       <= '0;
            missed_reg    <= '0;
            dropped_reg   <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            fill_reg      <= fill_next;
            remaining_reg <= remaining_next;
            rd_ptr_reg    <= rd_ptr_next;
            issued_reg    <= issued_next;
            cfo_reg       <= cfo_next;
            missed_reg    <= missed_next;
            dropped_reg   <= dropped_next;
            busy_reg      <= (state_next != ARMED);
        end
    end

    // Skid pointers, occupancy and the read-in-flight tracker
    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_reg        <= 1'b0;
            tail_reg        <= 1'b0;
            count_reg       <= 2'd0;
            rd_inflight_reg <= 1'b0;
            rd_last_reg     <= 1'b0;
        end else begin
            head_reg        <= head_reg ^ pop;
            tail_reg        <= tail_reg ^ push;
            count_reg       <= count_after;
            rd_inflight_reg <= rd_issue;
            rd_last_reg     <= rd_issue && rd_issue_last;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_skid
            logic [SW-1:0] data_reg;
            logic          last_reg;

            // Capture returning RAM data into this slot when the tail points here
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    data_reg <= '0;
                    last_reg <= 1'b0;
                end else if (push && (tail_reg == 1'(gi))) begin
                    data_reg <= ram_rd_data;
                    last_reg <= rd_last_reg;
                end
            end
        end
    endgenerate

    assign head_data = head_reg ? g_skid[1].data_reg : g_skid[0].data_reg;
    assign head_last = head_reg ? g_skid[1].last_reg : g_skid[0].last_reg;

    assign m_axis_tvalid        = (count_reg != 2'd0);
    assign m_axis_tdata         = head_data;
    assign m_axis_tlast         = m_axis_tvalid && head_last;
    assign m_axis_tuser         = cfo_reg;
    assign busy                 = busy_reg;
    assign missed_trigger_count = missed_reg;
    assign dropped_sample_count = dropped_reg;

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Scoreboard bench for frame_capture_buffer: stimulus pushes the expected
// beats of each frame, a monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_frame_capture_buffer;

    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int PRE   = 32;
    localparam int FL    = 256;
    localparam int TOTAL = PRE + FL;

    typedef struct packed {
        logic [2*DW-1:0] data;
        logic            last;
        logic [CW-1:0]   user;
        logic            first;
    } beat_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic [DW-1:0]   adc_i, adc_q;
    logic            en_i, val_i, en_q, val_q;
    logic            nirq;
    logic [CW-1:0]   cfo;
    logic [2*DW-1:0] tdata;
    logic            tvalid, tready, tlast;
    logic [CW-1:0]   tuser;
    logic            busy;
    logic [15:0]     missed;
    logic [31:0]     dropped;

    always #5 clk = ~clk;

    frame_capture_buffer dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .adc_data_i0          (adc_i),
        .adc_data_q0          (adc_q),
        .adc_enable_i0        (en_i),
        .adc_valid_i0         (val_i),
        .adc_enable_q0        (en_q),
        .adc_valid_q0         (val_q),
        .frame_detected_nirq  (nirq),
        .cfo_estimate         (cfo),
        .m_axis_tdata         (tdata),
        .m_axis_tvalid        (tvalid),
        .m_axis_tready        (tready),
        .m_axis_tlast         (tlast),
        .m_axis_tuser         (tuser),
        .busy                 (busy),
        .missed_trigger_count (missed),
        .dropped_sample_count (dropped)
    );

    int    checks = 0;
    int    failures = 0;
    int    n = 0;
    bit    bp_mode = 1'b0;
    int    beats_seen = 0;
    int    cyc = 0;
    int    first_cyc = 0;
    int    last_span = 0;
    int    exp_missed = 0;
    int    exp_dropped = 0;
    beat_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        en_i = 1'b0; val_i = 1'b0; en_q = 1'b0; val_q = 1'b0;
        nirq = 1'b1; cfo = '0;
    endtask

    // One fully qualified sample I = n, Q = -n
    task automatic send(input bit trig, input logic [CW-1:0] c);
        adc_i = 16'(n);
        adc_q = 16'(-n);
        en_i = 1'b1; val_i = 1'b1; en_q = 1'b1; val_q = 1'b1;
        nirq = ~trig;
        cfo  = c;
        tick;
        n++;
        idle_inputs;
    endtask

    // A sample missing one qualifier: must never reach the ring
    task automatic send_partial;
        adc_i = 16'h7777;
        adc_q = 16'h7777;
        en_i = 1'b1; val_i = 1'b1; en_q = 1'b1; val_q = 1'b0;
        tick;
        idle_inputs;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        idle_inputs;
        repeat (3) tick;
        rstn = 1'b1;
        n = 0;
        exp_missed = 0;
        exp_dropped = 0;
        beats_seen = 0;
        exp_q.delete();
    endtask

    task automatic push_frame(input int trig_n, input logic [CW-1:0] c);
        int base;
        beat_t b;
        base = trig_n - PRE;
        for (int k = 0; k < TOTAL; k++) begin
            b.data  = {16'(-(base + k)), 16'(base + k)};
            b.last  = (k == TOTAL - 1);
            b.first = (k == 0);
            b.user  = c;
            exp_q.push_back(b);
        end
    endtask

    // Trigger on the next sample, finish the capture, send 5 samples during
    // readout, then wait for the frame to drain.
    task automatic capture_frame(input logic [CW-1:0] c, input bit trig_cap, input bit trig_ro);
        int k;
        int trig_n;
        trig_n = n;
        push_frame(n, c);
        send(1'b1, c);
        check("busy_after_trigger", busy, 1);
        for (int s = 1; s < FL; s++) send(trig_cap && (s == 100), '0);
        if (trig_cap) exp_missed++;
        for (int s = 0; s < 5; s++) send(trig_ro && (s == 2), '0);
        if (trig_ro) exp_missed++;
        exp_dropped += 5;
        k = 0;
        while (busy && k < 3000) begin
            tick;
            k++;
        end
        check("busy_fall_in_time", k < 3000, 1);
        check("queue_drained_at_busy_fall", exp_q.size(), 0);
        check("missed_count", missed, exp_missed);
        check("dropped_count", dropped, exp_dropped);
        if (!bp_mode) check("frame_span_cycles", last_span, TOTAL);
        $display("frame trig_sample=%0d cfo=0x%h bp=%0d missed=%0d dropped=%0d",
                 trig_n, c, bp_mode, missed, dropped);
    endtask

    // Sink ready: always high, or random in backpressure mode
    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare every handshake against the scoreboard, and check
    // that a stalled beat is held unchanged.
    initial begin
        beat_t e;
        bit stall;
        logic [2*DW-1:0] h_data;
        logic h_last;
        logic [CW-1:0] h_user;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn !== 1'b1) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                checks++;
                if (!(tvalid === 1'b1 && tdata === h_data && tlast === h_last && tuser === h_user)) begin
                    failures++;
                    $display("FAIL stall_hold actual=v%0b/0x%h/%0b/0x%h required=v1/0x%h/%0b/0x%h",
                             tvalid, tdata, tlast, tuser, h_data, h_last, h_user);
                end
            end
            if (tvalid === 1'b1 && tready === 1'b1) begin
                stall = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat actual=0x%h required=none", tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (tdata !== e.data || tlast !== e.last || tuser !== e.user) begin
                        failures++;
                        $display("FAIL beat%0d actual=0x%h/last%0b/0x%h required=0x%h/last%0b/0x%h",
                                 beats_seen, tdata, tlast, tuser, e.data, e.last, e.user);
                    end
                    if (e.first) first_cyc = cyc;
                    if (e.last) last_span = cyc - first_cyc + 1;
                end
                beats_seen++;
            end else if (tvalid === 1'b1) begin
                stall  = 1'b1;
                h_data = tdata;
                h_last = tlast;
                h_user = tuser;
            end else begin
                stall = 1'b0;
            end
        end
    end

    // Directed stimulus
    initial begin
        int k;
        adc_i = '0;
        adc_q = '0;
        idle_inputs;

        // Reset values
        rstn = 1'b0;
        repeat (3) tick;
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tuser", tuser, 0);
        check("rst_busy", busy, 0);
        check("rst_missed", missed, 0);
        check("rst_dropped", dropped, 0);
        do_reset;
        $display("test reset done");

        // Basic capture, with one partially qualified sample in the history
        for (int s = 0; s < 90; s++) send(1'b0, '0);
        send_partial;
        for (int s = 90; s < 100; s++) send(1'b0, '0);
        capture_frame(16'h1234, 1'b0, 1'b0);

        // Backpressure
        do_reset;
        bp_mode = 1'b1;
        for (int s = 0; s < 100; s++) send(1'b0, '0);
        capture_frame(16'h1234, 1'b0, 1'b0);
        bp_mode = 1'b0;

        // Ring wrap: readout spans addresses 448..511,0..223
        do_reset;
        for (int s = 0; s < 480; s++) send(1'b0, '0);
        capture_frame(16'h5A5A, 1'b0, 1'b0);

        // Early trigger, then extra triggers during capture and readout
        do_reset;
        for (int s = 0; s < 10; s++) send(1'b0, '0);
        send(1'b1, 16'hDEAD);
        exp_missed++;
        check("early_trigger_missed", missed, exp_missed);
        check("early_trigger_not_busy", busy, 0);
        for (int s = 11; s < 150; s++) send(1'b0, '0);
        check("early_trigger_no_beats", beats_seen, 0);
        capture_frame(16'h0F0F, 1'b1, 1'b1);

        // Reset mid-readout, then rebuild history
        do_reset;
        for (int s = 0; s < 100; s++) send(1'b0, '0);
        push_frame(n, 16'h4242);
        send(1'b1, 16'h4242);
        for (int s = 1; s < FL; s++) send(1'b0, '0);
        k = 0;
        while (beats_seen < 50 && k < 1000) begin
            tick;
            k++;
        end
        check("beat50_reached", k < 1000, 1);
        rstn = 1'b0;
        tick;
        check("midreset_tvalid", tvalid, 0);
        check("midreset_tlast", tlast, 0);
        check("midreset_busy", busy, 0);
        exp_q.delete();
        tick;
        rstn = 1'b1;
        exp_missed = 0;
        exp_dropped = 0;
        for (int s = 0; s < 20; s++) send(1'b0, '0);
        send(1'b1, 16'h1111);
        exp_missed++;
        check("post_reset_trigger_missed", missed, exp_missed);
        check("post_reset_trigger_not_busy", busy, 0);
        for (int s = 0; s < 40; s++) send(1'b0, '0);
        capture_frame(16'hBEEF, 1'b0, 1'b0);

        repeat (5) tick;
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog against a hung run
    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
